// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the 8x8 memory cell array access path.
package mem_ctrl_pkg;

   localparam int ROWS  = 8;
   localparam int AW    = 3;
   localparam int DW    = 8;
   localparam int CNT_W = 4;

   // Access sequencer states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_e;

   // Grant encoding
   localparam logic GNT_A = 1'b0;
   localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input arbiter. Round-robin by default; fixed priority to port A when
// MEM_ARB_PRIORITY_A_EN is defined (last_grant is then ignored).
module rr_arbiter_2
   import mem_ctrl_pkg::*;
(
   input  logic req_a,
   input  logic req_b,
   input  logic last_grant,
   output logic gnt_valid,
   output logic gnt
);

   // Pick a winner among the active requests
   always_comb begin
      gnt_valid = req_a | req_b;
      gnt       = GNT_A;
`ifdef MEM_ARB_PRIORITY_A_EN
      if (!req_a && req_b) begin
         gnt = GNT_B;
      end
`else
      if (req_a && req_b) begin
         gnt = (last_grant == GNT_A) ? GNT_B : GNT_A;
      end else if (req_b) begin
         gnt = GNT_B;
      end
`endif
   end

`ifdef MEM_ARB_PRIORITY_A_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_access_arbiter.sv
// Two-port arbiter and access sequencer for the 8x8 memory cell array.
// Sequence per access: IDLE (arbitrate) -> SETUP (address setup) ->
// ACCESS (strobe for ACC_CYCLES) -> DONE (ack).
// Handshake: a requester holds req/we/adr/wdata stable until its ack pulse
// and drops req on the edge that samples ack; req still high in the next
// IDLE cycle is a new request.
// Optional macro: MEM_ARB_PRIORITY_A_EN (fixed priority to port A).
module mem_access_arbiter #(
   parameter int DW         = 8,
   parameter int AW         = 3,
   parameter int ACC_CYCLES = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_adr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_ack,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_adr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_ack,
   output logic [DW-1:0] b_rdata,
   output logic [AW-1:0] mem_adr,
   output logic          mem_re,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic [1:0]    dbg_state
);
   import mem_ctrl_pkg::*;

   if (ACC_CYCLES < 1 || ACC_CYCLES > 15) begin : g_bad_acc_cycles
      $error("ACC_CYCLES must be in 1..15");
   end

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYCLES - 1);

   state_e           state_q, state_d;
   logic             we_q, we_d;
   logic [AW-1:0]    adr_q, adr_d;
   logic [DW-1:0]    wdata_q, wdata_d;
   logic             gnt_q, gnt_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    a_rdata_q, a_rdata_d;
   logic [DW-1:0]    b_rdata_q, b_rdata_d;
   logic             arb_valid;
   logic             arb_gnt;

   rr_arbiter_2 u_arb (
      .req_a      (a_req),
      .req_b      (b_req),
      .last_grant (last_q),
      .gnt_valid  (arb_valid),
      .gnt        (arb_gnt)
   );

   // State and datapath registers; reset drops strobes immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         adr_q     <= '0;
         wdata_q   <= '0;
         gnt_q     <= GNT_A;
         last_q    <= GNT_B;
         cnt_q     <= '0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         wdata_q   <= wdata_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
   end

   // Next-state logic: latch winner in IDLE, count strobe cycles in ACCESS
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      adr_d     = adr_q;
      wdata_d   = wdata_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               gnt_d   = arb_gnt;
               we_d    = (arb_gnt == GNT_B) ? b_we    : a_we;
               adr_d   = (arb_gnt == GNT_B) ? b_adr   : a_adr;
               wdata_d = (arb_gnt == GNT_B) ? b_wdata : a_wdata;
               state_d = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = CNT_LOAD;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               if (!we_q) begin
                  if (gnt_q == GNT_B) b_rdata_d = mem_rdata;
                  else                a_rdata_d = mem_rdata;
               end
               state_d = DONE;
            end
         end
         DONE: begin
            last_d  = gnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_adr   = adr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = (state_q == ACCESS) &&  we_q;
   assign mem_re    = (state_q == ACCESS) && !we_q;
   assign a_ack     = (state_q == DONE) && (gnt_q == GNT_A);
   assign b_ack     = (state_q == DONE) && (gnt_q == GNT_B);
   assign a_rdata   = a_rdata_q;
   assign b_rdata   = b_rdata_q;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Two-requester arbiter and access sequencer for the 8x8 memory cell array (8 rows x 8 bits).
- Accepts one read or write request at a time from port A or port B and grants ports round-robin.
- Drives the 3-bit row address into the row decoder, holds it one setup cycle, then pulses the row read or write strobe.
- Returns a one-cycle ack and, for reads, the captured row data.

Parameters:
- DW, 8, data width of one row.
- AW, 3, row address width (2^AW rows).
- ACC_CYCLES, 1, number of cycles the read/write strobe is held high; legal range 1..15.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- a_req  input  1  port A request; level, held until a_ack.
- a_we  input  1  port A direction: 1 = write, 0 = read.
- a_adr  input  AW  port A row address.
- a_wdata  input  DW  port A write data.
- a_ack  output  1  port A completion pulse, 1 cycle.
- a_rdata  output  DW  port A read data; valid while a_ack=1, held afterwards.
- b_req, b_we, b_adr, b_wdata, b_ack, b_rdata: same as the port A signals, for port B.
- mem_adr  output  AW  row address to the decoder (bit0 -> adr0 ... bit2 -> adr2).
- mem_re  output  1  row read strobe.
- mem_we  output  1  row write strobe.
- mem_wdata  output  DW  write data to the array.
- mem_rdata  input  DW  row data from the array; valid while mem_re=1.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state = IDLE; last_grant = B, so A wins the first contention.
- FSM states: IDLE, SETUP, ACCESS, DONE.
  - IDLE: if any req is high, arbitrate, register the winner's we/adr/wdata and the grant, then go to SETUP. Otherwise stay in IDLE.
  - SETUP (1 cycle): mem_adr and mem_wdata are driven from the registered request; strobes are low. Go to ACCESS and load cnt = ACC_CYCLES-1.
  - ACCESS: mem_we = latched we, mem_re = ~latched we. While cnt > 0, decrement. At cnt = 0, a read registers mem_rdata into the granted port's rdata register, then go to DONE.
  - DONE (1 cycle): strobes low; mem_adr is held; the granted port's ack = 1; last_grant = the granted port. Go to IDLE.
- Latency: request seen in IDLE at cycle N -> ack at cycle N+2+ACC_CYCLES. The default setting gives ack at N+3, one access per 4 cycles.
- Handshake: the requester holds req, we, adr and wdata stable until ack. It drops req on the edge that samples ack. If req is still high in the following IDLE cycle, it is a new request.
- Arbitration:
  - Single requester: that requester is granted.
  - Both requesting: the port that is not last_grant wins.
  - The losing request stays pending; it is never dropped.
- mem_adr and mem_wdata change only on the IDLE -> SETUP edge. mem_re and mem_we are never high together.
- Per-port rdata updates only on that port's read completion. A write ack leaves rdata unchanged.
- A req that deasserts before ack is a protocol violation. The latched access still completes and the ack is still issued.
- Reset mid-operation: the FSM goes to IDLE and strobes go low immediately, with no ack. If reset hits during a write in ACCESS, the target row content is undefined.
- An ACC_CYCLES value outside 1..15 is a compile-time error.

Optional Feature:
- Macro: MEM_ARB_PRIORITY_A_EN.
- Defined: fixed priority; A always wins simultaneous requests; last_grant is ignored. B can be starved.
- Undefined: round-robin as specified above.

Decomposition:
- Package mem_ctrl_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/DONE);
  - the ROWS=8, AW=3 and DW=8 constants;
  - the grant encoding (GNT_A=0, GNT_B=1).
- Sub-module rr_arbiter_2: a two-input round-robin pick.
  - Inputs: req_a, req_b, last_grant.
  - Outputs: gnt_valid, gnt.
  - Contains the MEM_ARB_PRIORITY_A_EN switch.

Test Plan:
- Write then read, A only, ACC_CYCLES=1:
  - Write: a_we=1, a_adr=5, a_wdata=8'hA5 -> mem_we high exactly 1 cycle with mem_adr=5; a_ack exactly 3 cycles after acceptance.
  - Read: a_adr=5 -> a_rdata=8'hA5 with a_ack.
- Simultaneous req after reset:
  - Both ports request a read (A row 1, B row 2) -> A served first, B's ack 4 cycles after A's ack.
  - Next contention -> B wins.
- Back-to-back, A and B both holding req for 4 transactions -> grant order A, B, A, B; busy drops only after the final ack.
- ACC_CYCLES=3 read -> mem_re high for 3 cycles; rdata is the value sampled on the last strobe cycle; ack at N+5.
- rst asserted during a port B write in ACCESS -> mem_we=0 and busy=0 asynchronously, no b_ack; after release, an A read of another row returns correct data.
- With MEM_ARB_PRIORITY_A_EN, A requesting continuously and B held high -> no b_ack while A is requesting; B served in the first IDLE cycle where a_req=0.
